score_engine: RTL and testbench
===============================

Name: score_engine

Overview:
- Parametrised successor of the game's per-sample score calculator.
- Accumulates a player score from a per-clock hit/miss trace sample, with:
  - streak combo bonus
  - one-shot bonus power-up
  - timed double-points power-up
  - saturating arithmetic (no wrap at zero or at max)
- Sits between the trace-compare logic and the score display/VGA path.

Parameters:
- SCORE_W, 32, score register width.
- STREAK_W, 8, streak counter width.
- HIT_POINTS, 300, base points per hit.
- MISS_POINTS, 100, points removed per miss.
- BONUS_POINTS, 150, extra points when power_up1 accompanies a hit.
- COMBO_THRESH, 5, streak length at or above which a hit earns combo bonus HIT_POINTS>>1.
- DOUBLE_CYCLES, 16, length in clocks of the double-points window (>=1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  game running; samples ignored when low.
- clear  in  1  synchronous score/streak clear.
- sample_valid  in  1  in_trace is valid this cycle.
- in_trace  in  1  1 = hit, 0 = miss.
- power_up1  in  1  bonus qualifier, sampled with a hit.
- power_up4  in  1  pulse; starts or retriggers the double window.
- score  out  SCORE_W  current score.
- streak  out  STREAK_W  consecutive hits.
- double_active  out  1  double window running.
- score_valid  out  1  one-cycle pulse: score updated last edge.
- high_score  out  SCORE_W  see Optional Feature.

Behaviour:
- Reset (async, active-high): score, streak, timer, double_active, score_valid and high_score all go to 0; FSM enters IDLE.
- FSM states:
  - IDLE: enable=0.
  - PLAY: enable=1, no double window.
  - DOUBLE: enable=1, timer>0.
- FSM transitions:
  - IDLE->PLAY when enable=1.
  - PLAY->DOUBLE on power_up4 (timer loaded with DOUBLE_CYCLES).
  - DOUBLE: timer decrements each clock. When timer==1 and no power_up4, next state is PLAY.
  - power_up4 in DOUBLE reloads timer to DOUBLE_CYCLES (no stacking).
  - Any state with enable=0 -> IDLE; timer cleared, score and streak held.
- A sample is accepted when sample_valid=1 and state is PLAY or DOUBLE (current state, before power_up4 on the same edge takes effect).
- Hit delta:
  - d = HIT_POINTS
  - + (HIT_POINTS>>1) if streak (pre-update) >= COMBO_THRESH
  - + BONUS_POINTS if power_up1
  - then d<<1 if state==DOUBLE
  - score = min(score + d, 2^SCORE_W-1)
  - streak increments, saturating at all-ones.
- Miss: score = (score > MISS_POINTS) ? score - MISS_POINTS : 0; streak cleared. Never doubled.
- power_up1 without an accepted hit has no effect.
- Latency: result registered on the accepting edge and visible on the following cycle. score_valid is high for exactly that cycle; otherwise 0.
- clear:
  - Priority over a sample in the same cycle.
  - Zeroes score, streak and timer; double_active=0.
  - State becomes PLAY if enable=1, else IDLE.
  - score_valid=1 for the following cycle.
- Intermediate sums use SCORE_W+2 bits before saturation.
- double_active is a registered copy of state==DOUBLE.

Optional Feature:
- Macro SCORE_HIGH_WATER_EN.
- Defined:
  - high_score register updates to score whenever the new score exceeds it.
  - clear does not reset it; only reset does.
- Undefined: high_score tied to 0, no register inferred.

Decomposition:
- Package score_pkg:
  - FSM state enum (IDLE, PLAY, DOUBLE)
  - default point constants
  - saturation helper constants (max value per width)
- One sub-module, sat_addsub: parametrised SCORE_W saturating add/subtract with floor 0 and ceiling all-ones. Instantiated once for the score update.
- Timer and FSM stay in score_engine.

Test Plan:
- Reset, enable=1, three hits (one per cycle) -> score 300, 600, 900 on successive cycles; streak 3; score_valid pulses each cycle.
- Floor: from 300, four misses -> 200, 100, 0, 0; streak 0; no wrap.
- Combo: six consecutive hits from 0 -> 300, …, 1500, then 1950 (sixth hit +450).
- Double window:
  - power_up4 pulse, hit the next cycle -> +600.
  - double_active falls 16 cycles after entry; next hit -> +300.
  - power_up4 at cycle 10 of the window extends it to 26 cycles.
- Bonus: hit with power_up1 from 0 -> 450; same inside double window -> +900. power_up1 with miss -> only -100.
- SCORE_W=12:
  - repeated hits saturate at 4095 on the 11th hit and hold.
  - async reset asserted mid-DOUBLE clears score, timer and double_active immediately.
  - enable low blocks samples.

Source files
------------

// File: rtl/score_pkg.sv
// Shared types and defaults for the score engine: FSM state encoding,
// default point values and saturation ceilings for common score widths.
package score_pkg;

   // Game-flow states: not running, running normally, double-points window open.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PLAY   = 2'd1,
      DOUBLE = 2'd2
   } state_t;

   // Default configuration of the scoring rules.
   localparam int DEF_SCORE_W       = 32;
   localparam int DEF_STREAK_W      = 8;
   localparam int DEF_HIT_POINTS    = 300;
   localparam int DEF_MISS_POINTS   = 100;
   localparam int DEF_BONUS_POINTS  = 150;
   localparam int DEF_COMBO_THRESH  = 5;
   localparam int DEF_DOUBLE_CYCLES = 16;

   // Ceiling values for the score widths the display path is built for.
   localparam logic [31:0] SAT_MAX_W32 = 32'hFFFF_FFFF;
   localparam logic [15:0] SAT_MAX_W16 = 16'hFFFF;
   localparam logic [11:0] SAT_MAX_W12 = 12'hFFF;

   // Largest value representable in w bits (w up to 63).
   function automatic longint unsigned sat_max(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/score_engine_sat_addsub.sv
// sat_addsub: unsigned add or subtract that clamps to [0, 2^W-1] instead of
// wrapping. The operand b carries two extra bits so a large delta is seen as
// an overflow rather than silently truncated.
module sat_addsub #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W+1:0] b,
   input  logic         sub,
   output logic [W-1:0] y
);

   localparam logic [W+1:0] MAX = {2'b00, {W{1'b1}}};

   logic [W+1:0] a_ext;
   logic [W+1:0] sum;

   // Widen, combine and clamp to the representable range.
   always_comb begin
      // NOTE: every variable written here gets a value first, so no path leaves it unassigned and no latch is inferred.
      a_ext = {2'b00, a};
      sum   = a_ext + b;
      y     = '0;
      if (sub) begin
         if (a_ext > b) begin
            y = W'(a_ext - b);
         end
      end else if (sum > MAX) begin
         y = {W{1'b1}};
      end else begin
         y = sum[W-1:0];
      end
   end

endmodule

// File: rtl/score_engine.sv
// score_engine: accumulates a player score from a per-clock hit/miss trace,
// with streak combo bonus, one-shot bonus, timed double-points window and
// saturating arithmetic. Results appear the cycle after the accepting edge,
// flagged by a one-cycle score_valid pulse.
// Optional high-water register: define SCORE_HIGH_WATER_EN to track the
// highest score since reset on high_score; otherwise high_score is 0.
module score_engine
   import score_pkg::*;
#(
   parameter int SCORE_W       = DEF_SCORE_W,
   parameter int STREAK_W      = DEF_STREAK_W,
   parameter int HIT_POINTS    = DEF_HIT_POINTS,
   parameter int MISS_POINTS   = DEF_MISS_POINTS,
   parameter int BONUS_POINTS  = DEF_BONUS_POINTS,
   parameter int COMBO_THRESH  = DEF_COMBO_THRESH,
   parameter int DOUBLE_CYCLES = DEF_DOUBLE_CYCLES
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                enable,
   input  logic                clear,
   input  logic                sample_valid,
   input  logic                in_trace,
   input  logic                power_up1,
   input  logic                power_up4,
   output logic [SCORE_W-1:0]  score,
   output logic [STREAK_W-1:0] streak,
   output logic                double_active,
   output logic                score_valid,
   output logic [SCORE_W-1:0]  high_score
);

   localparam int TIMER_W = $clog2(DOUBLE_CYCLES + 1);
   localparam int DELTA_W = SCORE_W + 2;

   state_t               state;
   state_t               state_next;
   logic [TIMER_W-1:0]   timer;
   logic [TIMER_W-1:0]   timer_next;

   logic                 accept;
   logic                 hit;
   logic                 miss;
   logic [DELTA_W-1:0]   hit_delta;
   logic [DELTA_W-1:0]   delta;
   logic [SCORE_W-1:0]   score_sat;
   logic [SCORE_W-1:0]   score_next;
   logic [STREAK_W-1:0]  streak_next;
   logic                 valid_next;

   // Next-state and window timer: clear and enable override the game flow.
   always_comb begin
      state_next = state;
      timer_next = timer;
      if (clear) begin
         state_next = enable ? PLAY : IDLE;
         timer_next = '0;
      end else if (!enable) begin
         state_next = IDLE;
         timer_next = '0;
      end else begin
         case (state)
            IDLE: state_next = PLAY;
            PLAY: begin
               if (power_up4) begin
                  state_next = DOUBLE;
                  timer_next = TIMER_W'(DOUBLE_CYCLES);
               end
            end
            DOUBLE: begin
               if (power_up4) begin
                  timer_next = TIMER_W'(DOUBLE_CYCLES);
               end else if (timer == TIMER_W'(1)) begin
                  state_next = PLAY;
                  timer_next = '0;
               end else begin
                  timer_next = timer - TIMER_W'(1);
               end
            end
            default: begin
               state_next = IDLE;
               timer_next = '0;
            end
         endcase
      end
   end

   // State register; double_active mirrors the DOUBLE state from its own flop.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
      if (reset) begin
         state         <= IDLE;
         timer         <= '0;
         double_active <= 1'b0;
      end else begin
         state         <= state_next;
         timer         <= timer_next;
         double_active <= (state_next == DOUBLE);
      end
   end

   // Sample acceptance and point delta, judged on the current (pre-edge) state.
   always_comb begin
      accept = sample_valid && enable && !clear && ((state == PLAY) || (state == DOUBLE));
      hit    = accept && in_trace;
      miss   = accept && !in_trace;

      hit_delta = DELTA_W'(HIT_POINTS);
      if (int'(streak) >= COMBO_THRESH) begin
         hit_delta = hit_delta + DELTA_W'(HIT_POINTS >> 1);
      end
      if (power_up1) begin
         hit_delta = hit_delta + DELTA_W'(BONUS_POINTS);
      end
      if (state == DOUBLE) begin
         hit_delta = hit_delta << 1;
      end

      delta = in_trace ? hit_delta : DELTA_W'(MISS_POINTS);
   end

   sat_addsub #(
      .W (SCORE_W)
   ) u_sat (
      .a   (score),
      .b   (delta),
      .sub (!in_trace),
      .y   (score_sat)
   );

   // Select the next score/streak: clear wins, then an accepted sample, else hold.
   always_comb begin
      score_next  = score;
      streak_next = streak;
      valid_next  = clear || accept;
      if (clear) begin
         score_next  = '0;
         streak_next = '0;
      end else if (hit) begin
         score_next  = score_sat;
         streak_next = (streak == {STREAK_W{1'b1}}) ? streak : streak + STREAK_W'(1);
      end else if (miss) begin
         score_next  = score_sat;
         streak_next = '0;
      end
   end

   // Score, streak and update strobe registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         score       <= '0;
         streak      <= '0;
         score_valid <= 1'b0;
      end else begin
         score       <= score_next;
         streak      <= streak_next;
         score_valid <= valid_next;
      end
   end

`ifdef SCORE_HIGH_WATER_EN
   // High-water mark: follows the score upward only; clear leaves it intact.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         high_score <= '0;
      end else if (score_next > high_score) begin
         high_score <= score_next;
      end
   end
`else
   assign high_score = '0;
`endif

endmodule

// File: tb/tb_score_engine.sv
// Bench for score_engine: a 32-bit and a 12-bit instance share one directed
// stimulus stream. A rule-level model (window countdown, plain integer score
// with min/max clamping) is compared against both on every falling edge, and
// hand-computed literals pin the model at key points.
module tb_score_engine;

   localparam int  HIT   = 300;
   localparam int  MISS  = 100;
   localparam int  BONUS = 150;
   localparam int  THR   = 5;
   localparam int  DCYC  = 16;
   localparam longint MAX_A = 64'd4294967295;
   localparam longint MAX_B = 64'd4095;

   logic clock = 1'b0;
   logic reset, enable, clear, sample_valid, in_trace, power_up1, power_up4;

   logic [31:0] score_a, high_a;
   logic [7:0]  streak_a;
   logic        dbl_a, valid_a;
   logic [11:0] score_b, high_b;
   logic [7:0]  streak_b;
   logic        dbl_b, valid_b;

   int n_checks = 0;
   int n_errors = 0;
   bit cmp_en   = 1'b0;

   // Model state
   bit     m_run;
   int     m_left;
   int     m_streak;
   bit     m_valid;
   longint m_sa, m_sb, m_ha, m_hb;

   always #5 clock = ~clock;

   score_engine u_dut_a (
      .clock(clock), .reset(reset), .enable(enable), .clear(clear),
      .sample_valid(sample_valid), .in_trace(in_trace),
      .power_up1(power_up1), .power_up4(power_up4),
      .score(score_a), .streak(streak_a), .double_active(dbl_a),
      .score_valid(valid_a), .high_score(high_a)
   );

   score_engine #(.SCORE_W(12)) u_dut_b (
      .clock(clock), .reset(reset), .enable(enable), .clear(clear),
      .sample_valid(sample_valid), .in_trace(in_trace),
      .power_up1(power_up1), .power_up4(power_up4),
      .score(score_b), .streak(streak_b), .double_active(dbl_b),
      .score_valid(valid_b), .high_score(high_b)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_left = 0; m_streak = 0; m_valid = 0;
      m_sa = 0; m_sb = 0; m_ha = 0; m_hb = 0;
   endtask

   function automatic longint add_clamp(input longint s, input longint d, input longint mx);
      return (s + d > mx) ? mx : s + d;
   endfunction

   // Rule-level model of one clock edge.
   task automatic model_edge();
      bit     dbl;
      longint d;
      dbl     = (m_left > 0);
      m_valid = 0;
      if (clear) begin
         m_sa = 0; m_sb = 0; m_streak = 0; m_left = 0;
         m_run = enable; m_valid = 1;
      end else if (!enable) begin
         m_run = 0; m_left = 0;
      end else begin
         if (m_run && sample_valid) begin
            m_valid = 1;
            if (in_trace) begin
               d = HIT;
               if (m_streak >= THR) d = d + HIT / 2;
               if (power_up1) d = d + BONUS;
               if (dbl) d = d * 2;
               m_sa = add_clamp(m_sa, d, MAX_A);
               m_sb = add_clamp(m_sb, d, MAX_B);
               if (m_streak < 255) m_streak++;
            end else begin
               m_sa = (m_sa > MISS) ? m_sa - MISS : 0;
               m_sb = (m_sb > MISS) ? m_sb - MISS : 0;
               m_streak = 0;
            end
         end
         if (!m_run) m_run = 1;
         else if (power_up4) m_left = DCYC;
         else if (m_left > 0) m_left--;
      end
`ifdef SCORE_HIGH_WATER_EN
      if (m_sa > m_ha) m_ha = m_sa;
      if (m_sb > m_hb) m_hb = m_sb;
`endif
   endtask

   always @(posedge clock) begin
      if (!reset) model_edge();
   end

   // Single compare process: every falling edge once the bench is running.
   always @(negedge clock) begin
      if (cmp_en && !reset) begin
         check("score_a",  longint'(score_a),  m_sa);
         check("score_b",  longint'(score_b),  m_sb);
         check("streak_a", longint'(streak_a), longint'(m_streak));
         check("streak_b", longint'(streak_b), longint'(m_streak));
         check("dbl_a",    longint'(dbl_a),    longint'(m_left > 0));
         check("dbl_b",    longint'(dbl_b),    longint'(m_left > 0));
         check("valid_a",  longint'(valid_a),  longint'(m_valid));
         check("valid_b",  longint'(valid_b),  longint'(m_valid));
         check("high_a",   longint'(high_a),   m_ha);
         check("high_b",   longint'(high_b),   m_hb);
      end
   end

   task automatic step(input bit c, input bit sv, input bit tr, input bit p1, input bit p4);
      clear = c; sample_valid = sv; in_trace = tr; power_up1 = p1; power_up4 = p4;
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic hit(input int n);
      for (int i = 0; i < n; i++) step(0, 1, 1, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      reset = 1; enable = 1; clear = 0; sample_valid = 0;
      in_trace = 0; power_up1 = 0; power_up4 = 0;
      model_reset();
      @(negedge clock);
      check("rst_score", longint'(score_a), 64'd0);
      check("rst_streak", longint'(streak_a), 64'd0);
      check("rst_dbl", longint'(dbl_a), 64'd0);
      check("rst_valid", longint'(valid_a), 64'd0);
      check("rst_high", longint'(high_a), 64'd0);
      @(negedge clock);
      reset = 0;
      cmp_en = 1;

      // Basic hits after IDLE->PLAY
      idle(1);
      step(0, 1, 1, 0, 0); check("hit1", longint'(score_a), 64'd300); check("hit1_v", longint'(valid_a), 64'd1);
      step(0, 1, 1, 0, 0); check("hit2", longint'(score_a), 64'd600);
      step(0, 1, 1, 0, 0); check("hit3", longint'(score_a), 64'd900); check("hit3_str", longint'(streak_a), 64'd3);

      // Floor at zero
      step(1, 1, 1, 0, 0); check("clr_score", longint'(score_a), 64'd0); check("clr_v", longint'(valid_a), 64'd1);
      step(0, 1, 1, 0, 0); check("fl_300", longint'(score_a), 64'd300);
      step(0, 1, 0, 0, 0); check("fl_200", longint'(score_a), 64'd200);
      step(0, 1, 0, 0, 0); check("fl_100", longint'(score_a), 64'd100);
      step(0, 1, 0, 0, 0); check("fl_0a", longint'(score_a), 64'd0);
      step(0, 1, 0, 0, 0); check("fl_0b", longint'(score_a), 64'd0); check("fl_str", longint'(streak_a), 64'd0);
      idle(1); check("fl_novalid", longint'(valid_a), 64'd0);

      // Combo bonus on the sixth hit
      step(1, 0, 0, 0, 0);
      hit(5); check("cmb_1500", longint'(score_a), 64'd1500);
      hit(1); check("cmb_1950", longint'(score_a), 64'd1950); check("cmb_str", longint'(streak_a), 64'd6);

      // Double window entry, length and expiry
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1); check("dbl_on", longint'(dbl_a), 64'd1);
      step(0, 1, 1, 0, 0); check("dbl_600", longint'(score_a), 64'd600);
      idle(14); check("dbl_still", longint'(dbl_a), 64'd1);
      idle(1);  check("dbl_off16", longint'(dbl_a), 64'd0);
      step(0, 1, 1, 0, 0); check("dbl_after", longint'(score_a), 64'd900);

      // Retrigger at window cycle 10 -> 26 cycles
      step(0, 0, 0, 0, 1);
      idle(9);
      step(0, 0, 0, 0, 1);
      idle(15); check("ext_still", longint'(dbl_a), 64'd1);
      idle(1);  check("ext_off26", longint'(dbl_a), 64'd0);

      // Bonus power-up
      step(1, 0, 0, 0, 0);
      step(0, 1, 1, 1, 0); check("bon_450", longint'(score_a), 64'd450);
      step(0, 0, 0, 0, 1);
      step(0, 1, 1, 1, 0); check("bon_dbl", longint'(score_a), 64'd1350);
      step(0, 1, 0, 1, 0); check("bon_miss", longint'(score_a), 64'd1250);

      // Enable low blocks samples and closes the window
      enable = 0;
      idle(1); check("en_dbl", longint'(dbl_a), 64'd0);
      hit(2);  check("en_hold", longint'(score_a), 64'd1250); check("en_novalid", longint'(valid_a), 64'd0);
      enable = 1;
      idle(1);
      hit(1);  check("en_resume", longint'(score_a), 64'd1550);

      // 12-bit saturation
      step(1, 0, 0, 0, 0);
      hit(10); check("sat_3750", longint'(score_b), 64'd3750);
      hit(1);  check("sat_4095", longint'(score_b), 64'd4095);
      hit(1);  check("sat_hold", longint'(score_b), 64'd4095); check("sat_wide", longint'(score_a), 64'd4650);

      // Asynchronous reset in the middle of a double window
      step(0, 0, 0, 0, 1);
      idle(1);
      #2 reset = 1;
      model_reset();
      #1;
      check("ar_score_a", longint'(score_a), 64'd0);
      check("ar_score_b", longint'(score_b), 64'd0);
      check("ar_dbl_a", longint'(dbl_a), 64'd0);
      check("ar_dbl_b", longint'(dbl_b), 64'd0);
      check("ar_streak", longint'(streak_a), 64'd0);
      @(negedge clock);
      reset = 0;
      idle(1);
      hit(1); check("ar_resume", longint'(score_a), 64'd300); check("ar_nodbl", longint'(dbl_a), 64'd0);

      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
